div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Sequencing controller for an iterative 32-bit radix-2 divider in the E stage of the 5-stage MIPS pipeline.
- Launches on DIV/DIVU alucontrol codes and runs 32 shift-subtract iterations.
- Holds the pipeline via a stall output, then presents HI (remainder) and LO (quotient) to the HI/LO write path.
- Handles flush, divide-by-zero and back-to-back divides.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- alucontrolE  in  8  E-stage ALU control; `EXE_DIV_OP selects signed, `EXE_DIVU_OP selects unsigned
- srcaE  in  WIDTH  dividend (rs)
- srcbE  in  WIDTH  divisor (rt)
- flushE  in  1  exception/ERET flush of the E stage
- advanceE  in  1  E stage advances this cycle (no stall anywhere)
- div_stall  out  1  request to hold F/D/E
- div_ready  out  1  result valid for the instruction in E
- div_hi  out  WIDTH  remainder
- div_lo  out  WIDTH  quotient

Behaviour:
- States: IDLE, RUN, DZERO, DONE. State register and all datapath registers are async-reset.
- Reset values: state=IDLE, counter=0, div_stall=0, div_ready=0, div_hi=0, div_lo=0.
- start = (alucontrolE==`EXE_DIV_OP || alucontrolE==`EXE_DIVU_OP) && !flushE.
- IDLE:
  - If start and srcbE==0: go to DZERO.
  - If start and srcbE!=0: latch |srcaE| and |srcbE| (magnitude only when signed), latch sign_q = a[31]^b[31] and sign_r = a[31] for signed ops (both 0 for DIVU), clear the partial remainder, counter=0, go to RUN.
- RUN: each cycle perform one restoring step.
  - {rem,quo} shifted left by 1; if rem >= divisor, subtract and set quotient bit 0 to 1.
  - counter increments; after WIDTH steps (counter==WIDTH-1 stepping), go to DONE.
- DZERO: one cycle, then DONE. Result is fixed: lo=32'hFFFF_FFFF, hi=srcaE as latched (raw, unsigned).
- DONE:
  - Signed fix-up has been applied on entry: lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem.
  - div_ready=1 and div_stall=0.
  - Stays in DONE while !advanceE, so other stall sources cannot cause a restart. Returns to IDLE when advanceE=1.
- div_stall = start && !(state==DONE). The stall is combinational from start, so it is asserted in the launch cycle itself.
- Latency:
  - Normal: launch cycle plus WIDTH RUN cycles, then DONE; ready in cycle WIDTH+1 after launch (33 for WIDTH=32).
  - Divide-by-zero: ready in cycle 2.
- flushE in any state: go to IDLE at the next edge, div_ready=0, no HI/LO update. div_hi/div_lo hold their last values.
- Back-to-back DIV: DONE → IDLE on advanceE, and the new instruction launches in the following cycle.
- Edge cases:
  - Most-negative / -1: magnitude arithmetic wraps, giving lo=32'h8000_0000 and hi=0. No trap.
  - Signed 0 dividend with negative divisor: hi=0 and lo=0; the negate of 0 is 0.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |a| < |b| (nonzero b), skip RUN and go directly to DONE with quo=0, rem=|a| (sign fix-up still applied). Ready in cycle 1.
- Undefined: every nonzero-divisor divide takes the full WIDTH iterations; the latency is data-independent.

Decomposition:
- Shared: `EXE_DIV_OP and `EXE_DIVU_OP already live in defines.vh. Add the state encodings DIV_IDLE/DIV_RUN/DIV_DZERO/DIV_DONE (2-bit) there.
- Sub-module div_step: combinational one-iteration restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- The controller instantiates div_step once; FSM, counter and sign fix-up stay in div_ctrl.

Test Plan:
- DIVU 100/7: alucontrolE=`EXE_DIVU_OP held, advanceE=0 until ready → div_stall=1 for 33 cycles, then div_ready=1, lo=14, hi=2.
- DIV -100/7 (32'hFFFF_FF9C / 7) → lo=32'hFFFF_FFF2 (-14), hi=32'hFFFF_FFFE (-2). DIV 100/-7 → lo=-14, hi=2.
- DIV 5/0 → ready in cycle 2, lo=32'hFFFF_FFFF, hi=5, stall lasts 2 cycles.
- flushE pulsed at RUN cycle 10 → state IDLE next cycle, div_ready never asserted, div_stall=0 once alucontrolE changes.
- Ready with advanceE=0 for 3 cycles (memory stall) → DONE held, div_ready=1 each cycle, no relaunch. Then advanceE=1 with a second DIVU 9/3 following → lo=3, hi=0.
- DIV_EARLY_OUT_EN defined, DIVU 3/10 → ready in cycle 1, lo=0, hi=3. Undefined → ready in cycle 33, same result.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
//   Shared definitions for the iterative divider sequencer in the E stage.
//   - EXE_DIV_OP / EXE_DIVU_OP : ALU control codes that launch a divide
//   - div_state_t              : 2-bit controller state encoding
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_RUN   = 2'd1,
    DIV_DZERO = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_ctrl_step.sv
// -----------------------------------------------------------------------------
// div_step
//   Combinational single iteration of a radix-2 restoring divider.
//   {rem,quo} is shifted left by one; if the shifted remainder is at least the
//   divisor, the divisor is subtracted and a 1 enters the quotient LSB.
// Ports:
//   rem      in  WIDTH  current partial remainder (always < divisor)
//   quo      in  WIDTH  current dividend/quotient shift register
//   divisor  in  WIDTH  divisor magnitude (nonzero)
//   rem_next out WIDTH  partial remainder after this step
//   quo_next out WIDTH  quotient register after this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The shifted remainder needs one extra bit: 2*rem+1 can exceed WIDTH bits
  // when the divisor sits in the upper half of the range.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // NOTE: every output gets a default before the conditional update, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      rem_next    = diff[WIDTH-1:0];
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
//   Sequencer for the iterative 32-bit divider in the E stage. Launches on
//   DIV/DIVU, runs WIDTH restoring steps (via div_step), applies the signed
//   fix-up and presents HI (remainder) / LO (quotient). Holds F/D/E with
//   div_stall until the result is ready; handles flush and divide-by-zero.
//   Build option: define DIV_EARLY_OUT_EN to finish in one cycle when
//   |dividend| < |divisor|.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   alucontrolE  E-stage ALU control (DIV signed, DIVU unsigned)
//   srcaE/srcbE  dividend / divisor
//   flushE       kill the E-stage instruction
//   advanceE     E stage advances this cycle
//   div_stall    hold F/D/E
//   div_ready    result valid for the instruction in E
//   div_hi/lo    remainder / quotient
// -----------------------------------------------------------------------------
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       alucontrolE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flushE,
  input  logic             advanceE,
  output logic             div_stall,
  output logic             div_ready,
  output logic [WIDTH-1:0] div_hi,
  output logic [WIDTH-1:0] div_lo
);

  div_state_t state, next_state;

  logic             start;
  logic             is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             early_out;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q, quo_q;
  logic             sign_q, sign_r;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             last_step;

  assign is_signed = (alucontrolE == EXE_DIV_OP);
  assign start     = (is_signed || alucontrolE == EXE_DIVU_OP) && !flushE;
  assign a_neg     = is_signed && srcaE[WIDTH-1];
  assign b_neg     = is_signed && srcbE[WIDTH-1];
  // The most-negative value negates to itself; read as unsigned it is the
  // correct magnitude, so MIN / -1 needs no special case.
  assign mag_a     = a_neg ? -srcaE : srcaE;
  assign mag_b     = b_neg ? -srcbE : srcbE;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (mag_a < mag_b);
`else
  assign early_out = 1'b0;
`endif

  // Stall is gated by reset so the pipeline sees a clean idle divider while
  // reset is held, even if a DIV code sits in E.
  assign div_stall = start && (state != DIV_DONE) && !rst;
  assign div_ready = (state == DIV_DONE) && !flushE;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      DIV_IDLE: begin
        if (start) begin
          if (srcbE == '0)    next_state = DIV_DZERO;
          else if (early_out) next_state = DIV_DONE;
          else                next_state = DIV_RUN;
        end
      end
      DIV_RUN: begin
        if (flushE)         next_state = DIV_IDLE;
        else if (last_step) next_state = DIV_DONE;
      end
      DIV_DZERO: next_state = flushE ? DIV_IDLE : DIV_DONE;
      // DONE is left only on advance (or flush) so a stall from elsewhere in
      // the pipeline cannot relaunch the same instruction.
      DIV_DONE: begin
        if (flushE || advanceE) next_state = DIV_IDLE;
      end
      default: next_state = DIV_IDLE;
    endcase
  end

  // NOTE: the datapath is small and its values are observable (HI/LO), so
  // every register here is reset rather than left undefined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      a_raw     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      div_hi    <= '0;
      div_lo    <= '0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (start) begin
            a_raw     <= srcaE;
            divisor_q <= mag_b;
            rem_q     <= '0;
            quo_q     <= mag_a;
            sign_q    <= a_neg ^ b_neg;
            sign_r    <= a_neg;
            cnt       <= '0;
            if (srcbE != '0 && early_out) begin
              div_lo <= '0;
              div_hi <= a_neg ? -mag_a : mag_a;
            end
          end
        end
        DIV_RUN: begin
          if (!flushE) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt   <= cnt + CNT_W'(1);
            if (last_step) begin
              div_lo <= sign_q ? -step_quo : step_quo;
              div_hi <= sign_r ? -step_rem : step_rem;
            end
          end
        end
        DIV_DZERO: begin
          if (!flushE) begin
            div_lo <= '1;
            div_hi <= a_raw;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
//   Self-checking bench for div_ctrl: a directed vector table, hand-written
//   flush / memory-stall / reset sequences, and randomized divides compared
//   against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int WIDTH = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int LAT_FULL  = WIDTH + 1;
  localparam int LAT_SMALL = EARLY ? 1 : LAT_FULL;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       alucontrolE;
  logic [WIDTH-1:0] srcaE, srcbE;
  logic             flushE, advanceE;
  logic             div_stall, div_ready;
  logic [WIDTH-1:0] div_hi, div_lo;

  int tests = 0;
  int fails = 0;

  div_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .alucontrolE (alucontrolE),
    .srcaE       (srcaE),
    .srcbE       (srcbE),
    .flushE      (flushE),
    .advanceE    (advanceE),
    .div_stall   (div_stall),
    .div_ready   (div_ready),
    .div_hi      (div_hi),
    .div_lo      (div_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic (truncating division, remainder takes
  // the dividend's sign), which is what MIPS DIV/DIVU define.
  function automatic void model(input logic [7:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] lo,
                                output logic [31:0] hi, output int lat);
    longint sa, sb, q, r, aa, ab;
    if (b == 0) begin
      lo = 32'hFFFF_FFFF; hi = a; lat = 2;
      return;
    end
    if (op == EXE_DIV_OP) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
    end else begin
      sa = longint'(a); sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    lo = q[31:0];
    hi = r[31:0];
    aa = (sa < 0) ? -sa : sa;
    ab = (sb < 0) ? -sb : sb;
    lat = (EARLY && aa < ab) ? 1 : LAT_FULL;
  endfunction

  // Called at a negedge with the divider idle. Launches, counts cycles to
  // ready, optionally holds DONE for `hold` cycles without advance, then
  // advances. Returns at a negedge with the divider back in IDLE.
  task automatic do_div(input string name, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] elo,
                        input logic [31:0] ehi, input int elat, input int hold);
    int lat = 0;
    int stalls = 0;
    alucontrolE = op; srcaE = a; srcbE = b; advanceE = 1'b0; flushE = 1'b0;
    #1;
    check({name, ".stall_launch"}, 32'(div_stall), 32'd1);
    stalls = 1;
    forever begin
      @(negedge clk);
      lat++;
      if (div_ready || lat > 100) break;
      if (div_stall) stalls++;
    end
    check({name, ".latency"}, 32'(lat), 32'(elat));
    check({name, ".stall_cycles"}, 32'(stalls), 32'(elat));
    check({name, ".lo"}, div_lo, elo);
    check({name, ".hi"}, div_hi, ehi);
    check({name, ".stall_done"}, 32'(div_stall), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, ".hold_ready"}, 32'(div_ready), 32'd1);
      check({name, ".hold_lo"}, div_lo, elo);
      check({name, ".hold_stall"}, 32'(div_stall), 32'd0);
    end
    advanceE = 1'b1;
    @(negedge clk);
    alucontrolE = 8'h00; advanceE = 1'b0;
    #1;
    check({name, ".ready_after_adv"}, 32'(div_ready), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] prev_lo, prev_hi, mlo, mhi, ra, rb;
    logic [7:0]  rop;
    int          mlat, rdy_seen;

    vecs.push_back('{"divu_100_7",   EXE_DIVU_OP, 32'd100,       32'd7,         32'd14,        32'd2,         LAT_FULL});
    vecs.push_back('{"div_m100_7",   EXE_DIV_OP,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, LAT_FULL});
    vecs.push_back('{"div_100_m7",   EXE_DIV_OP,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         LAT_FULL});
    vecs.push_back('{"div_5_0",      EXE_DIV_OP,  32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         2});
    vecs.push_back('{"div_min_m1",   EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         LAT_FULL});
    vecs.push_back('{"div_0_m7",     EXE_DIV_OP,  32'd0,         32'hFFFF_FFF9, 32'd0,         32'd0,         LAT_SMALL});
    vecs.push_back('{"divu_3_10",    EXE_DIVU_OP, 32'd3,         32'd10,        32'd0,         32'd3,         LAT_SMALL});
    vecs.push_back('{"divu_max_1",   EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         LAT_FULL});
    vecs.push_back('{"div_m7_2",     EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT_FULL});
    vecs.push_back('{"divu_neg0",    EXE_DIVU_OP, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 32'h8000_0000, 2});
    vecs.push_back('{"div_m3_m10",   EXE_DIV_OP,  32'hFFFF_FFFD, 32'hFFFF_FFF6, 32'd0,         32'hFFFF_FFFD, LAT_SMALL});

    rst = 1'b1; alucontrolE = 8'h00; srcaE = '0; srcbE = '0;
    flushE = 1'b0; advanceE = 1'b0;
    @(negedge clk); @(negedge clk);
    check("reset.stall", 32'(div_stall), 32'd0);
    check("reset.ready", 32'(div_ready), 32'd0);
    check("reset.lo", div_lo, 32'd0);
    check("reset.hi", div_hi, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      do_div(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].lo, vecs[i].hi, vecs[i].lat, 0);

    // Flush in the middle of RUN: no result, HI/LO untouched, no relaunch.
    prev_lo = div_lo; prev_hi = div_hi;
    alucontrolE = EXE_DIVU_OP; srcaE = 32'd1000; srcbE = 32'd3;
    repeat (10) @(negedge clk);
    flushE = 1'b1;
    #1;
    check("flush.stall_during", 32'(div_stall), 32'd0);
    @(negedge clk);
    flushE = 1'b0; alucontrolE = 8'h00;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_ready || div_stall) rdy_seen++;
    end
    check("flush.no_ready_or_stall", 32'(rdy_seen), 32'd0);
    check("flush.lo_held", div_lo, prev_lo);
    check("flush.hi_held", div_hi, prev_hi);

    // Memory stall holds DONE for 3 cycles, then a back-to-back DIVU 9/3.
    do_div("hold_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, LAT_FULL, 3);
    do_div("b2b_9_3", EXE_DIVU_OP, 32'd9, 32'd3, 32'd3, 32'd0, LAT_FULL, 0);

    // Reset in the middle of RUN.
    alucontrolE = EXE_DIVU_OP; srcaE = 32'd77; srcbE = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.stall", 32'(div_stall), 32'd0);
    check("midrst.ready", 32'(div_ready), 32'd0);
    check("midrst.lo", div_lo, 32'd0);
    check("midrst.hi", div_hi, 32'd0);
    @(negedge clk);
    rst = 1'b0; alucontrolE = 8'h00;
    @(negedge clk);
    do_div("post_rst", EXE_DIVU_OP, 32'd77, 32'd5, 32'd15, 32'd2, LAT_FULL, 0);

    // Randomized divides against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2, 3: rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20))
                                                  : -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 30)) : $urandom;
      model(rop, ra, rb, mlo, mhi, mlat);
      do_div($sformatf("rand%0d", n), rop, ra, rb, mlo, mhi, mlat, n % 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
